// File: rtl/system_data_sync_pkg.sv
// Shared defaults for the enable-qualified bus synchronizer.
// A global WIDTH macro, when defined, overrides the default bus width.
`ifndef WIDTH
`define WIDTH 8
`endif

package system_data_sync_pkg;

  localparam int unsigned DEFAULT_WIDTH = `WIDTH;

  localparam int unsigned DEFAULT_NUM_STAGES = 2;
  localparam int unsigned MIN_NUM_STAGES     = 2;

endpackage

// File: rtl/system_data_sync_bit_sync.sv
// Single-bit multi-flop synchronizer chain with synchronous active-low reset.
// There is no logic between stages, so metastability has a full cycle to resolve.
module bit_sync
    import system_data_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/system_data_sync.sv
// Bus synchronizer: only the enable crosses through a flop chain; a rising edge
// on the synchronized enable captures the whole bus once and emits a 1-cycle strobe.
module system_data_sync
    import system_data_sync_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_data,
    input  logic             en_async,
    output logic [WIDTH-1:0] sync_data,
    output logic             sync
);

    logic             w_en_sync;
    logic             w_pulse;
    logic             r_pulse;
    logic             r_sync;
    logic [WIDTH-1:0] r_sync_data;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_en_sync (
        .clk (clk),
        .rst (rst),
        .i_d (en_async),
        .o_q (w_en_sync)
    );

    // r_pulse holds the previous synchronized enable for rising-edge detection
    assign w_pulse = w_en_sync & ~r_pulse;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pulse     <= 1'b0;
            r_sync      <= 1'b0;
            r_sync_data <= '0;
        end else begin
            r_pulse <= w_en_sync;
            r_sync  <= w_pulse;
            if (w_pulse) begin
                r_sync_data <= async_data;
            end
        end
    end

    assign sync_data = r_sync_data;
    assign sync      = r_sync;

endmodule

// File: tb/tb_system_data_sync.sv
// Self-checking bench for system_data_sync (WIDTH=8, NUM_STAGES=2): directed
// vector table, hand-written multi-cycle sequences and a randomized model check.
module tb_system_data_sync;

    logic       clk;
    logic       rst;
    logic [7:0] async_data;
    logic       en_async;
    logic [7:0] sync_data;
    logic       sync;

    int n_cmp;
    int n_bad;

    system_data_sync #(
        .WIDTH(8),
        .NUM_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .async_data (async_data),
        .en_async   (en_async),
        .sync_data  (sync_data),
        .sync       (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of enable samples since the last reset edge.
    // A capture happens two edges after the enable was first seen high, and
    // only if it was low (or reset) on the edge before that.
    logic       m_hist[$];
    logic [7:0] m_data;
    logic       m_sync;

    task automatic model_edge();
        int idx;
        if (!rst) begin
            m_hist.delete();
            m_data = 8'h00;
            m_sync = 1'b0;
        end else begin
            m_hist.push_back(en_async);
            idx    = m_hist.size() - 3;
            m_sync = 1'b0;
            if (idx >= 0) begin
                if (m_hist[idx] && (idx == 0 || !m_hist[idx-1])) begin
                    m_sync = 1'b1;
                    m_data = async_data;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] data;
        logic       exp_sync;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[19];

    int strobes;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        en_async   = 1'b0;
        async_data = 8'h00;
        m_data     = 8'h00;
        m_sync     = 1'b0;

        // reset with enable high, then capture 3 edges after release
        vecs[0]  = '{1'b0, 1'b1, 8'h6B, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h6B, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 8'h6B, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 8'h6B, 1'b1, 8'h6B};
        vecs[4]  = '{1'b1, 1'b0, 8'h6B, 1'b0, 8'h6B};
        vecs[5]  = '{1'b1, 1'b0, 8'h6B, 1'b0, 8'h6B};
        vecs[6]  = '{1'b1, 1'b0, 8'h6B, 1'b0, 8'h6B};
        // single 1-cycle pulse with 0xA5
        vecs[7]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h6B};
        vecs[8]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'h6B};
        vecs[9]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5};
        vecs[10] = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5};
        vecs[11] = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5};
        // back-to-back 1,0,1 with 0x11 then 0x22
        vecs[12] = '{1'b1, 1'b1, 8'h11, 1'b0, 8'hA5};
        vecs[13] = '{1'b1, 1'b0, 8'h11, 1'b0, 8'hA5};
        vecs[14] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h11};
        vecs[15] = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h11};
        vecs[16] = '{1'b1, 1'b0, 8'h22, 1'b1, 8'h22};
        vecs[17] = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h22};
        vecs[18] = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h22};

        for (int i = 0; i < 19; i++) begin
            rst        = vecs[i].rst;
            en_async   = vecs[i].en;
            async_data = vecs[i].data;
            tick();
            check($sformatf("vec%0d_sync", i), {7'd0, sync}, {7'd0, vecs[i].exp_sync});
            check($sformatf("vec%0d_data", i), sync_data, vecs[i].exp_data);
        end

        // held enable: 20 cycles high, data changes after the capture
        strobes    = 0;
        en_async   = 1'b1;
        async_data = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sync) strobes++;
            if (i == 2) async_data = 8'h77;
        end
        en_async = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sync) strobes++;
        end
        check("held_strobes", 8'(strobes), 8'd1);
        check("held_data", sync_data, 8'h3C);

        // mid-chain reset discards the in-flight enable
        strobes    = 0;
        en_async   = 1'b1;
        async_data = 8'h5A;
        tick();
        en_async = 1'b0;
        rst      = 1'b0;
        tick();
        check("midrst_data_in_reset", sync_data, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sync) strobes++;
        end
        check("midrst_strobes", 8'(strobes), 8'd0);
        check("midrst_data", sync_data, 8'h00);

        // randomized events checked every cycle against the model
        rst = 1'b0;
        tick();
        rst = 1'b1;
        begin
            int exp_strobes;
            int gap;
            exp_strobes = 0;
            strobes     = 0;
            for (int ev = 0; ev < 100; ev++) begin
                async_data = 8'($urandom);
                en_async   = 1'b1;
                gap        = int'($urandom_range(0, 9));
                tick();
                if (sync) strobes++;
                if (m_sync) exp_strobes++;
                check("rnd_sync", {7'd0, sync}, {7'd0, m_sync});
                check("rnd_data", sync_data, m_data);
                en_async = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (sync) strobes++;
                    if (m_sync) exp_strobes++;
                    check("rnd_sync", {7'd0, sync}, {7'd0, m_sync});
                    check("rnd_data", sync_data, m_data);
                end
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                if (sync) strobes++;
                if (m_sync) exp_strobes++;
                check("rnd_sync", {7'd0, sync}, {7'd0, m_sync});
                check("rnd_data", sync_data, m_data);
            end
            check("rnd_strobe_count", 8'(strobes), 8'(exp_strobes));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
